// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: datapath width, opcodes,
// the fetch FSM encoding and the IF/ID payload layout.
package cpu_pkg;
  localparam int XLEN = 16;

  localparam logic [3:0]      HALT_OPCODE = 4'hF;
  localparam logic [XLEN-1:0] NOP_INSTR   = 16'h0000;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc2;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that arrived while ID was stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       clear_i,
  input  fetch_pkt_t data_i,
  output logic       valid_o,
  output fetch_pkt_t data_o
);
  logic       valid_q;
  fetch_pkt_t data_q;

  // Clear wins over load: a redirect must never leave a squashed entry behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues valid-hold requests to instruction
// memory and feeds IF/ID, handling stall, redirect squash and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = cpu_pkg::NOP_INSTR,
  parameter logic [3:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        if_wen,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        instr_valid_out,
  output logic        halted
);
  import cpu_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, hold_addr_q, hold_addr_d, pc_inc;
  logic            drop_q, drop_d;
  logic            accept, is_hlt;
  logic            buf_valid, buf_load, buf_clear;
  fetch_pkt_t      buf_in, buf_out;

  assign pc_inc   = pc_q + 16'd2;
  assign imem_req = (state_q == FS_RUN) & ~buf_valid & ~rst;
  // A squashed request keeps presenting its original address until it completes.
  assign imem_addr = drop_q ? hold_addr_q : pc_q;
  assign accept    = imem_valid & imem_req & ~drop_q & ~redirect_valid;
  assign is_hlt    = (imem_data[15:12] == HALT_OPCODE);
  assign halted    = (state_q == FS_HALTED) & ~rst;

  assign buf_load  = accept & stall;
  assign buf_clear = redirect_valid | (~stall & buf_valid);
  assign buf_in    = '{instr: imem_data, pc2: pc_inc};

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (buf_load),
    .clear_i(buf_clear),
    .data_i (buf_in),
    .valid_o(buf_valid),
    .data_o (buf_out)
  );

  always_comb begin
    if_wen          = 1'b1;
    instr_out       = NOP_INSTR;
    pc_plus2_out    = 16'h0000;
    instr_valid_out = 1'b0;
    pc_d            = pc_q;
    state_d         = state_q;
    drop_d          = drop_q;
    hold_addr_d     = hold_addr_q;
    if (rst) begin
      // reset cycle: flush IF/ID with a bubble, no state advance
    end else if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = FS_RUN;
      if (imem_req && !imem_valid) begin
        drop_d      = 1'b1;
        hold_addr_d = imem_addr;
      end else begin
        drop_d = 1'b0;
      end
    end else begin
      if (drop_q && imem_valid) drop_d = 1'b0;
      // HLT parks the PC on its own address; only a redirect restarts fetch.
      if (accept) begin
        if (is_hlt) state_d = FS_HALTED;
        else        pc_d    = pc_inc;
      end
      if (stall) begin
        if_wen = 1'b0;
      end else if (buf_valid) begin
        instr_out       = buf_out.instr;
        pc_plus2_out    = buf_out.pc2;
        instr_valid_out = 1'b1;
      end else if (accept) begin
        instr_out       = imem_data;
        pc_plus2_out    = pc_inc;
        instr_valid_out = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      state_q     <= FS_RUN;
      drop_q      <= 1'b0;
      hold_addr_q <= RESET_PC;
    end else begin
      pc_q        <= pc_d;
      state_q     <= state_d;
      drop_q      <= drop_d;
      hold_addr_q <= hold_addr_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order fetch model with a wait-state memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_valid;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, if_wen, instr_valid_out, halted;
  logic [15:0] imem_addr, instr_out, pc_plus2_out;

  int checks = 0;
  int errors = 0;

  // memory model state
  bit          req_active = 0;
  bit          rand_wait  = 0;
  int          wait_left  = 0;
  int          next_wait  = 0;
  logic [15:0] cur_addr   = '0;
  logic [15:0] halt_addr  = 16'hFFFF;
  logic        req_s, vld_s;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_data      (imem_data),
    .if_wen         (if_wen),
    .instr_out      (instr_out),
    .pc_plus2_out   (pc_plus2_out),
    .instr_valid_out(instr_valid_out),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Program image: opcode field never 4'hF except at halt_addr.
  function automatic logic [15:0] word(input logic [15:0] a);
    if (a == halt_addr) return 16'hF000;
    return {1'b0, a[15:1]} ^ 16'h2A5A;
  endfunction

  // Drive inputs just after negedge, then let memory answer the current request.
  task automatic drive(input logic s, input logic rv, input logic [15:0] rp);
    stall = s; redirect_valid = rv; redirect_pc = rp;
    #1;
    if (imem_req) begin
      if (!req_active || imem_addr != cur_addr) begin
        req_active = 1;
        cur_addr   = imem_addr;
        wait_left  = rand_wait ? int'($urandom_range(0, 2)) : next_wait;
      end
      imem_valid = (wait_left == 0);
      imem_data  = imem_valid ? word(cur_addr) : 16'hDEAD;
    end else begin
      imem_valid = 1'b0;
      imem_data  = 16'hDEAD;
    end
    #1;
    req_s = imem_req;
    vld_s = imem_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst)                      req_active = 0;
    else if (req_s && vld_s)      req_active = 0;
    else if (req_s && wait_left > 0) wait_left--;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp 0", imem_req); end
    checks++; if (if_wen !== 1'b1) begin errors++; $display("FAIL reset_wen got %h exp 1", if_wen); end
    checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", instr_out); end
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", instr_valid_out); end
    checks++; if (pc_plus2_out !== 16'h0000) begin errors++; $display("FAIL reset_pc2 got %h exp 0000", pc_plus2_out); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %h exp 0", halted); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_straight();
    next_wait = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      checks++; if (imem_addr !== 16'(2*i)) begin errors++; $display("FAIL straight_addr got %h exp %h", imem_addr, 16'(2*i)); end
      checks++; if (if_wen !== 1'b1 || instr_valid_out !== 1'b1) begin errors++; $display("FAIL straight_wen_valid got %b%b exp 11", if_wen, instr_valid_out); end
      checks++; if (instr_out !== word(16'(2*i))) begin errors++; $display("FAIL straight_instr got %h exp %h", instr_out, word(16'(2*i))); end
      checks++; if (pc_plus2_out !== 16'(2*i+2)) begin errors++; $display("FAIL straight_pc2 got %h exp %h", pc_plus2_out, 16'(2*i+2)); end
      tick();
    end
  endtask

  task automatic test_wait_states();
    next_wait = 2;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 16'h0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("FAIL wait_addr got %b/%h exp 1/0004", imem_req, imem_addr); end
      checks++; if (if_wen !== 1'b1 || instr_valid_out !== (c == 2)) begin errors++; $display("FAIL wait_deliver c=%0d got %b%b", c, if_wen, instr_valid_out); end
      if (c == 2) begin
        checks++; if (pc_plus2_out !== 16'h0006) begin errors++; $display("FAIL wait_pc2 got %h exp 0006", pc_plus2_out); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    next_wait = 1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 16'h0);
      checks++; if (if_wen !== 1'b0) begin errors++; $display("FAIL stall_wen c=%0d got %h exp 0", c, if_wen); end
      checks++; if (imem_req !== (c < 2)) begin errors++; $display("FAIL stall_req c=%0d got %h exp %h", c, imem_req, (c < 2)); end
      tick();
    end
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (if_wen !== 1'b1 || instr_valid_out !== 1'b1) begin errors++; $display("FAIL stall_release got %b%b exp 11", if_wen, instr_valid_out); end
    checks++; if (instr_out !== word(16'h0006) || pc_plus2_out !== 16'h0008) begin errors++; $display("FAIL stall_buf got %h/%h exp %h/0008", instr_out, pc_plus2_out, word(16'h0006)); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_buf_req got %h exp 0", imem_req); end
    tick();
    next_wait = 0;
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin errors++; $display("FAIL stall_next_addr got %b/%h exp 1/0008", imem_req, imem_addr); end
    checks++; if (instr_valid_out !== 1'b1 || pc_plus2_out !== 16'h000A) begin errors++; $display("FAIL stall_next_pc2 got %b/%h exp 1/000a", instr_valid_out, pc_plus2_out); end
    tick();
  endtask

  task automatic test_redirect();
    int k;
    next_wait = 3;
    drive(1'b0, 1'b1, 16'h0040);
    checks++; if (imem_addr !== 16'h000A) begin errors++; $display("FAIL redir_addr got %h exp 000a", imem_addr); end
    checks++; if (if_wen !== 1'b1 || instr_valid_out !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b%b exp 10", if_wen, instr_valid_out); end
    tick();
    next_wait = 0;
    for (k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 16'h0);
      if (imem_addr !== 16'h000A) break;
      checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL redir_drop got %h exp 0", instr_valid_out); end
      tick();
    end
    checks++; if (k >= 8) begin errors++; $display("FAIL redir_timeout got %0d cycles exp <8", k); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_new_addr got %h exp 0040", imem_addr); end
    checks++; if (instr_valid_out !== 1'b1 || pc_plus2_out !== 16'h0042) begin errors++; $display("FAIL redir_pc2 got %b/%h exp 1/0042", instr_valid_out, pc_plus2_out); end
    tick();
  endtask

  task automatic test_halt();
    halt_addr = 16'h0010;
    drive(1'b0, 1'b1, 16'h0010);
    tick();
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (instr_valid_out !== 1'b1 || instr_out !== 16'hF000 || pc_plus2_out !== 16'h0012) begin errors++; $display("FAIL hlt_deliver got %b/%h/%h exp 1/f000/0012", instr_valid_out, instr_out, pc_plus2_out); end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 16'h0);
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL hlt_state got halted=%h req=%h exp 1/0", halted, imem_req); end
      checks++; if (instr_valid_out !== 1'b0 || if_wen !== 1'b1) begin errors++; $display("FAIL hlt_bubble got %b%b exp 10", if_wen, instr_valid_out); end
      checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL hlt_pc got %h exp 0010", imem_addr); end
      tick();
    end
    drive(1'b0, 1'b1, 16'h0020);
    tick();
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin errors++; $display("FAIL hlt_resume got %b/%b/%h exp 0/1/0020", halted, imem_req, imem_addr); end
    checks++; if (instr_valid_out !== 1'b1 || pc_plus2_out !== 16'h0022) begin errors++; $display("FAIL hlt_resume_pc2 got %b/%h exp 1/0022", instr_valid_out, pc_plus2_out); end
    tick();
    halt_addr = 16'hFFFF;
  endtask

  task automatic test_wrap_and_reset();
    drive(1'b0, 1'b1, 16'hFFFE);
    tick();
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (imem_addr !== 16'hFFFE || pc_plus2_out !== 16'h0000 || instr_valid_out !== 1'b1) begin errors++; $display("FAIL wrap_pc2 got %h/%h/%b exp fffe/0000/1", imem_addr, pc_plus2_out, instr_valid_out); end
    tick();
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h exp 0000", imem_addr); end
    tick();
    drive(1'b0, 1'b1, 16'h0030);
    tick();
    next_wait = 5;
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (imem_addr !== 16'h0030 || imem_valid !== 1'b0) begin errors++; $display("FAIL midrst_setup got %h exp 0030", imem_addr); end
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0);
    imem_valid = 1'b1;
    imem_data  = word(16'h0030);
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_cycle got %b/%b exp 0/0", imem_req, instr_valid_out); end
    tick();
    rst = 1'b0;
    next_wait = 1;
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_addr got %b/%h/%b exp 1/0000/0", imem_req, imem_addr, instr_valid_out); end
    tick();
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (instr_valid_out !== 1'b1 || instr_out !== word(16'h0000) || pc_plus2_out !== 16'h0002) begin errors++; $display("FAIL midrst_fetch got %b/%h/%h exp 1/%h/0002", instr_valid_out, instr_out, pc_plus2_out, word(16'h0000)); end
    tick();
  endtask

  // Reference: the program-order stream of {instr, pc+2}. Accepted fetches are
  // queued and delivered in order; a redirect empties the queue and retargets.
  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] item;
    logic [15:0] fetch_pc, stale_addr, rp;
    bit          halt_m, stale, exp_req, acc, s, rv, exp_wen, exp_v;
    int          delivered;
    fetch_pc = 16'h0000; halt_m = 0; stale = 0; stale_addr = '0; delivered = 0;
    rst = 1'b1; drive(1'b0, 1'b0, 16'h0); tick(); rst = 1'b0;
    rand_wait = 1;
    halt_addr = 16'h0026;
    for (int n = 0; n < 3000; n++) begin
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 15) == 0);
      rp = 16'($urandom_range(0, 31)) * 16'd2;
      drive(s, rv, rp);
      exp_req = !halt_m && (q.size() == 0);
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req n=%0d got %h exp %h", n, imem_req, exp_req); end
      if (exp_req) begin
        checks++; if (imem_addr !== (stale ? stale_addr : fetch_pc)) begin errors++; $display("FAIL rnd_addr n=%0d got %h exp %h", n, imem_addr, stale ? stale_addr : fetch_pc); end
      end
      checks++; if (halted !== halt_m) begin errors++; $display("FAIL rnd_halted n=%0d got %h exp %h", n, halted, halt_m); end
      acc = exp_req && imem_valid && !stale && !rv;
      if (acc) q.push_back({word(fetch_pc), fetch_pc + 16'd2});
      exp_v = 0; item = '0;
      if (rv)        exp_wen = 1;
      else if (s)    exp_wen = 0;
      else begin
        exp_wen = 1;
        if (q.size() > 0) begin exp_v = 1; item = q.pop_front(); end
      end
      checks++; if (if_wen !== exp_wen || instr_valid_out !== exp_v) begin errors++; $display("FAIL rnd_wen_valid n=%0d got %b%b exp %b%b", n, if_wen, instr_valid_out, exp_wen, exp_v); end
      if (exp_v) begin
        delivered++;
        checks++; if ({instr_out, pc_plus2_out} !== item) begin errors++; $display("FAIL rnd_data n=%0d got %h/%h exp %h/%h", n, instr_out, pc_plus2_out, item[31:16], item[15:0]); end
      end else if (exp_wen) begin
        checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL rnd_bubble n=%0d got %h exp 0000", n, instr_out); end
      end
      if (rv) begin
        q.delete();
        halt_m = 0;
        if (stale) stale = !imem_valid;
        else if (exp_req && !imem_valid) begin stale = 1; stale_addr = fetch_pc; end
        fetch_pc = rp;
      end else begin
        if (stale && imem_valid) stale = 0;
        if (acc) begin
          if (word(fetch_pc) == 16'hF000) halt_m = 1;
          else fetch_pc = fetch_pc + 16'd2;
        end
      end
      tick();
    end
    checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress got %0d deliveries exp >=100", delivered); end
    rand_wait = 0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_data = '0;
    @(negedge clk);
    test_reset();
    test_straight();
    test_wait_states();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
